alu_op_sequencer: RTL and testbench

- Upstream issue stage for the 8-bit ALU unit.
- Owns the 8 x 8-bit operand register file and accepts 16-bit instruction words over a valid/ready handshake.
- Reads source registers and drives opA/opB/opcode/cin to the ALU, waits the ALU latency, then writes the result back to the register file and data_out.
- Also handles immediate loads of data_in into a register without using the ALU.

---
 rtl/alu_op_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage in front of the 8-bit ALU.
// Holds the 8 x 8-bit operand register file and accepts one 16-bit
// instruction at a time over a valid/ready handshake. For an ALU op it
// presents the operands, waits ALU_LAT cycles and writes the result back.
// For LOAD_OP it writes data_in into rd without involving the ALU.
// Optional feature: define ZERO_FLAG_EN to add the zero_flag output, which
// is updated on every writeback.
module alu_op_sequencer #(
    parameter int         ALU_LAT = 1,      // 1..7
    parameter logic [3:0] LOAD_OP = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [7:0]  data_in,
    output logic [7:0]  alu_opA,
    output logic [7:0]  alu_opB,
    output logic [3:0]  alu_op,
    output logic        alu_cin,
    input  logic [7:0]  alu_result,
    input  logic        alu_cout,
    output logic [7:0]  data_out,
    output logic        carry_flag,
    output logic        wb_valid,
    output logic        busy
`ifdef ZERO_FLAG_EN
    ,
    output logic        zero_flag
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // Counter preload so that WB lands exactly ALU_LAT cycles after ISSUE.
    localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  r_rd;
    logic        r_is_load;
    logic [7:0]  r_imm;
    logic [7:0]  r_regs [8];

    logic        w_accept;
    logic [3:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_ra;
    logic [2:0]  w_rb;
    logic        w_use_carry;
    logic [1:0]  w_unused_rsvd;
    logic [7:0]  w_wb_data;

    assign w_op          = instr[15:12];
    assign w_rd          = instr[11:9];
    assign w_ra          = instr[8:6];
    assign w_rb          = instr[5:3];
    assign w_unused_rsvd = instr[2:1];
    assign w_use_carry   = instr[0];

    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign w_accept    = instr_valid && instr_ready;
    assign w_wb_data   = r_is_load ? r_imm : alu_result;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; loads skip the ALU entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_op == LOAD_OP) ? S_WB : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = (CNT_INIT == 3'd0) ? S_WB : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latency counter: preloaded in ISSUE, counted down through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= CNT_INIT;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Capture the instruction at accept; ALU outputs hold until the next ALU accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd      <= 3'd0;
            r_is_load <= 1'b0;
            r_imm     <= 8'h00;
            alu_opA   <= 8'h00;
            alu_opB   <= 8'h00;
            alu_op    <= 4'h0;
            alu_cin   <= 1'b0;
        end else if (w_accept) begin
            r_rd      <= w_rd;
            r_is_load <= (w_op == LOAD_OP);
            if (w_op == LOAD_OP) begin
                r_imm <= data_in;
            end else begin
                alu_opA <= r_regs[w_ra];
                alu_opB <= r_regs[w_rb];
                alu_op  <= w_op;
                alu_cin <= w_use_carry ? carry_flag : 1'b0;
            end
        end
    end

    // Writeback at the edge closing the WB cycle; loads leave the carry alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
            data_out   <= 8'h00;
            carry_flag <= 1'b0;
`ifdef ZERO_FLAG_EN
            zero_flag  <= 1'b0;
`endif
        end else if (r_state == S_WB) begin
            r_regs[r_rd] <= w_wb_data;
            data_out     <= w_wb_data;
            if (!r_is_load) begin
                carry_flag <= alu_cout;
            end
`ifdef ZERO_FLAG_EN
            zero_flag    <= (w_wb_data == 8'h00);
`endif
        end
    end

    // wb_valid is high for exactly the WB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= (w_state_nxt == S_WB);
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with ALU_LAT=3 and a behavioural ALU.
module tb_alu_op_sequencer;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  data_in;
    logic [7:0]  alu_opA;
    logic [7:0]  alu_opB;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [7:0]  alu_result;
    logic        alu_cout;
    logic [7:0]  data_out;
    logic        carry_flag;
    logic        wb_valid;
    logic        busy;
`ifdef ZERO_FLAG_EN
    logic        zero_flag;
`endif

    alu_op_sequencer #(.ALU_LAT(LAT), .LOAD_OP(4'hF)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .data_in(data_in),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .data_out(data_out), .carry_flag(carry_flag),
        .wb_valid(wb_valid), .busy(busy)
`ifdef ZERO_FLAG_EN
        , .zero_flag(zero_flag)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: {cout, result}.
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        logic [7:0] r;
        case (op[2:0])
            3'd0, 3'd1: r = a + b;
            3'd2:       r = a - b;
            3'd3:       r = a & b;
            3'd4:       r = a | b;
            3'd5:       r = a ^ b;
            3'd6:       r = {a[6:0], a[7]};
            default:    r = ~b;
        endcase
        r = r + {7'd0, cin};
        if (op[3]) r = r ^ 8'h5A;
        return {^r, r};
    endfunction

    // External ALU: result is only correct in the cycle LAT+1 after the accept edge.
    int k = 0;
    logic [8:0] f_now;
    assign f_now      = alu_f(alu_op, alu_opA, alu_opB, alu_cin);
    assign alu_result = (k == LAT + 1) ? f_now[7:0] : ~f_now[7:0];
    assign alu_cout   = (k == LAT + 1) ? f_now[8]   : ~f_now[8];

    always @(posedge clk) begin
        if (rst) k <= 0;
        else if (instr_valid && instr_ready && instr[15:12] != 4'hF) k <= 1;
        else if (k != 0 && k < 15) k <= k + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0] m_reg [8];
    logic       m_carry;
    logic       m_zero;
    logic [7:0] m_a, m_b;
    logic [3:0] m_op;
    logic       m_cin;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       z;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_carry = 1'b0; m_zero = 1'b0;
        m_a = 8'h00; m_b = 8'h00; m_op = 4'h0; m_cin = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every wb_valid and checks the committed value next cycle.
    logic pend = 1'b0;
    exp_t pcur;
    always @(negedge clk) begin
        exp_t cur;
        if (pend) begin
            chk("data_out", {24'd0, data_out}, {24'd0, pcur.d});
            chk("carry_flag", {31'd0, carry_flag}, {31'd0, pcur.c});
`ifdef ZERO_FLAG_EN
            chk("zero_flag", {31'd0, zero_flag}, {31'd0, pcur.z});
`endif
            pend = 1'b0;
        end
        if (wb_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_valid=1 expected 0 (t=%0t)", $time);
            end else begin
                cur = sbq.pop_front();
                chk("wb_latency", cyc, cur.cyc);
                pcur = cur;
                pend = 1'b1;
            end
        end
    end

    // Issue one instruction (called at a negedge); returns at a negedge with instr_valid low.
    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input logic uc, input logic [7:0] din,
                        input int hold);
        int n = 0;
        logic [1:0] rsv;
        logic [8:0] f;
        exp_t e;
        rsv = 2'($urandom);
        instr = {op, rd, ra, rb, rsv, uc};
        data_in = din;
        instr_valid = 1'b1;
        while (instr_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 32'd1, 32'd0);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (op == 4'hF) begin
            m_reg[rd] = din;
            m_zero = (din == 8'h00);
            e.d = din; e.c = m_carry; e.z = m_zero; e.cyc = cyc + 1;
        end else begin
            m_a = m_reg[ra]; m_b = m_reg[rb]; m_op = op; m_cin = uc ? m_carry : 1'b0;
            f = alu_f(m_op, m_a, m_b, m_cin);
            m_reg[rd] = f[7:0];
            m_carry = f[8];
            m_zero = (f[7:0] == 8'h00);
            e.d = f[7:0]; e.c = f[8]; e.z = m_zero; e.cyc = cyc + 1 + LAT;
        end
        sbq.push_back(e);
        @(negedge clk);
        chk("ready_low_after_accept", {31'd0, instr_ready}, 32'd0);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("alu_opA", {24'd0, alu_opA}, {24'd0, m_a});
        chk("alu_opB", {24'd0, alu_opB}, {24'd0, m_b});
        chk("alu_op", {28'd0, alu_op}, {28'd0, m_op});
        chk("alu_cin", {31'd0, alu_cin}, {31'd0, m_cin});
        if (op == 4'hF) hold = 0;
        else if (hold > LAT) hold = LAT;
        repeat (hold) @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; data_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, then idle for 10 cycles.
        @(negedge clk);
        chk("rst_alu_opA", {24'd0, alu_opA}, 32'd0);
        chk("rst_alu_opB", {24'd0, alu_opB}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_alu_cin", {31'd0, alu_cin}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_carry", {31'd0, carry_flag}, 32'd0);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef ZERO_FLAG_EN
        chk("rst_zero", {31'd0, zero_flag}, 32'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
            @(negedge clk);
        end

        // Load reg3 = A5 via instr F600; ready is low for exactly one cycle.
        instr = 16'hF600;
        send(4'hF, 3'd3, 3'd0, 3'd0, 1'b0, 8'hA5, 0);
        @(negedge clk);
        chk("load_ready_back", {31'd0, instr_ready}, 32'd1);
        chk("load_data_out", {24'd0, data_out}, 32'h0000_00A5);
        chk("load_carry_kept", {31'd0, carry_flag}, 32'd0);

        // reg1=10, reg2=22, then op1 rd4 ra1 rb2 -> 32 with cout 1.
        send(4'hF, 3'd1, 3'd0, 3'd0, 1'b0, 8'h10, 0);
        send(4'hF, 3'd2, 3'd0, 3'd0, 1'b0, 8'h22, 0);
        send(4'h1, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00, 0);
        repeat (LAT + 1) @(negedge clk);
        chk("add_data_out", {24'd0, data_out}, 32'h0000_0032);
        chk("add_carry", {31'd0, carry_flag}, 32'd1);

        // Carry chaining with carry_flag=1, then without.
        send(4'h0, 3'd5, 3'd1, 3'd2, 1'b1, 8'h00, 0);
        send(4'h0, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 0);

        // Dependency on reg4 while holding valid through the whole busy window.
        send(4'h5, 3'd7, 3'd4, 3'd3, 1'b0, 8'h00, LAT);
        send(4'h2, 3'd4, 3'd4, 3'd4, 1'b1, 8'h00, LAT);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            send(op, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                 8'($urandom), int'($urandom_range(0, LAT)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Zero-flag loads.
        send(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 0);
        send(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 8'h01, 0);
        repeat (3) @(negedge clk);

        // Make reg6 non-zero, then reset during WAIT of an op targeting reg6.
        send(4'hF, 3'd6, 3'd0, 3'd0, 1'b0, 8'h5C, 0);
        repeat (3) @(negedge clk);
        instr = {4'h4, 3'd6, 3'd6, 3'd1, 2'b00, 1'b0};
        instr_valid = 1'b1;
        while (instr_ready !== 1'b1) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data_out", {24'd0, data_out}, 32'd0);
        chk("abort_carry", {31'd0, carry_flag}, 32'd0);
        for (int i = 0; i < LAT + 3; i++) begin
            chk("abort_no_wb", {31'd0, wb_valid}, 32'd0);
            @(negedge clk);
        end
        // Reading reg6 must now see zero.
        send(4'h6, 3'd0, 3'd6, 3'd6, 1'b0, 8'h00, 0);

        repeat (LAT + 4) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        chk("final_idle", {31'd0, instr_ready}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
